// File: rtl/pcs_codes_pkg.sv
// PCS fill codes shared by the TX FIFO and the link checkers.
// One place for IDLE/SYNC/LANEOK encodings so producers and checkers cannot drift apart.
package pcs_codes_pkg;

    localparam logic [11:0] PCS_IDLE        = 12'h555;
    localparam logic [11:0] PCS_SYNC        = 12'hAAA;
    localparam logic [3:0]  PCS_LANEOK_HEAD = 4'hB;

    function automatic logic [11:0] laneok_word(input logic [3:0] head, input logic [7:0] status);
        return {head, status};
    endfunction

endpackage

// File: rtl/tx_fifo_mem.sv
// DEPTH x 12 register array: one synchronous write port, two asynchronous read ports
// so the two oldest words can be emitted in a single pop.
module tx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [11:0]   wdata_i,
    input  logic [AW-1:0] raddr0_i,
    input  logic [AW-1:0] raddr1_i,
    output logic [11:0]   rdata0_o,
    output logic [11:0]   rdata1_o
);

    logic [11:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/tx_fifo.sv
// Transmit FIFO packing up to two 12-bit words per pop into a 24-bit beat,
// with periodic SYNC insertion and one-shot LANEOK reporting in spare slots.
module tx_fifo
    import pcs_codes_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter int          SYNC_PERIOD = 256,
    parameter logic [11:0] IDLE        = PCS_IDLE,
    parameter logic [11:0] SYNC        = PCS_SYNC,
    parameter logic [3:0]  LANEOK_HEAD = PCS_LANEOK_HEAD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [11:0]              wr_data,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    input  logic [7:0]               lane_ok,
    input  logic                     pop,
    output logic [1:0]               en_rd,
    output logic [23:0]              data_rd
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SYNC_PERIOD);

    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          overflow_q;
    logic [CW-1:0] pop_cnt_q;
    logic          sync_q;
    logic [7:0]    lane_ok_q;
    logic          laneok_q;

    logic          push_ok;
    logic [11:0]   rdata0, rdata1;
    logic [11:0]   fill_word;
    logic [11:0]   slot0, slot1;
    logic [1:0]    en_c;
    logic [1:0]    n_pop;
    logic          sync_clr;
    logic          laneok_used;

    assign push_ok = wr_en & ~full_q;

    tx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk      (clk),
        .we_i     (push_ok),
        .waddr_i  (wr_ptr_q[AW-1:0]),
        .wdata_i  (wr_data),
        .raddr0_i (rd_ptr_q[AW-1:0]),
        .raddr1_i (rd_ptr_q[AW-1:0] + AW'(1)),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    assign fill_word = laneok_q ? laneok_word(LANEOK_HEAD, lane_ok_q) : IDLE;

    // Slot packing: a pending SYNC always takes the low slot; spare slots get LANEOK once, then IDLE.
    always_comb begin
        en_c        = 2'b00;
        slot0       = IDLE;
        slot1       = IDLE;
        n_pop       = 2'd0;
        sync_clr    = 1'b0;
        laneok_used = 1'b0;
        if (pop) begin
            if (sync_q) begin
                slot0    = SYNC;
                sync_clr = 1'b1;
                if (level_q != '0) begin
                    en_c  = 2'b10;
                    slot1 = rdata0;
                    n_pop = 2'd1;
                end else begin
                    slot1       = fill_word;
                    laneok_used = laneok_q;
                end
            end else if (level_q >= LW'(2)) begin
                en_c  = 2'b11;
                slot0 = rdata0;
                slot1 = rdata1;
                n_pop = 2'd2;
            end else if (level_q == LW'(1)) begin
                en_c        = 2'b01;
                slot0       = rdata0;
                slot1       = fill_word;
                n_pop       = 2'd1;
                laneok_used = laneok_q;
            end else begin
                slot0       = fill_word;
                laneok_used = laneok_q;
            end
        end
    end

    assign en_rd   = reset ? 2'b00 : en_c;
    assign data_rd = reset ? {IDLE, IDLE} : {slot1, slot0};

    always_comb begin
        wr_ptr_d = wr_ptr_q + LW'(push_ok);
        rd_ptr_d = rd_ptr_q + LW'(n_pop);
        level_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            pop_cnt_q  <= '0;
            sync_q     <= 1'b1;
            lane_ok_q  <= '0;
            laneok_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            overflow_q <= overflow_q | (wr_en & full_q);
            lane_ok_q  <= lane_ok;
            if (pop) begin
                pop_cnt_q <= pop_cnt_q + CW'(1);
            end
            // Wrap of the pop counter re-arms SYNC; set has priority over the clear.
            if (pop && (&pop_cnt_q)) begin
                sync_q <= 1'b1;
            end else if (sync_clr) begin
                sync_q <= 1'b0;
            end
            if (lane_ok != lane_ok_q) begin
                laneok_q <= 1'b1;
            end else if (laneok_used) begin
                laneok_q <= 1'b0;
            end
        end
    end

    assign level    = level_q;
    assign full     = full_q;
    assign overflow = overflow_q;

endmodule

// File: doc/tx_fifo.md
TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO depth in 12-bit words (power of 2, >=4).
REQ-002 Parameter SYNC_PERIOD, default 256, meaning pops between forced SYNC insertions (power of 2).
REQ-003 Parameters IDLE=12'h555, SYNC=12'hAAA, LANEOK_HEAD=4'hB, meaning fill codes.
REQ-004 Clock/reset: one clock, clk; reset is asynchronous and active-high, port reset.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 wr_en  in  1  push request for wr_data.
REQ-008 wr_data  in  12  payload word.
REQ-009 full  out  1  registered; 1 when occupancy == DEPTH.
REQ-010 overflow  out  1  sticky; set by wr_en while full.
REQ-011 level  out  log2(DEPTH)+1  registered occupancy.
REQ-012 lane_ok  in  8  lane status, sampled every cycle.
REQ-013 pop  in  1  consumer read strobe.
REQ-014 en_rd  out  2  per-slot data valid; bit0 -> data_rd[11:0], bit1 -> data_rd[23:12].
REQ-015 data_rd  out  24  two 12-bit slots, valid combinationally in the pop cycle.

Function
REQ-016 Storage: DEPTH x 12 circular buffer, wr_ptr/rd_ptr with extra wrap bit; full/empty from pointer compare.
REQ-017 Push accepted when wr_en && !full (pre-edge value); word visible to pop from next cycle.
REQ-018 Push while full: word dropped, overflow set, pointers unchanged.
REQ-019 pop consumes only pre-edge contents; simultaneous push+pop legal at any level, including full (push rejected, pop proceeds).
REQ-020 pop=0: en_rd=00, data_rd={IDLE,IDLE}, no state change.
REQ-021 Slot packing on pop, no SYNC pending: level>=2 -> en_rd=11, older word [11:0], newer [23:12]; level==1 -> en_rd=01, word [11:0], fill [23:12]; level==0 -> en_rd=00, fill both.
REQ-022 SYNC pending on pop: [11:0]=SYNC; level>=1 -> en_rd=10, oldest word [23:12]; level==0 -> en_rd=00, fill [23:12]; sync_pending cleared.
REQ-023 Fill-slot priority (other than SYNC slot): LANEOK word {LANEOK_HEAD, lane_ok_reg} if laneok_pending, else IDLE; at most one LANEOK per pop, in lowest free fill slot; laneok_pending then cleared.
REQ-024 laneok_pending set when lane_ok differs from lane_ok_reg (registered copy); set wins over clear in same cycle.
REQ-025 pop_cnt (log2(SYNC_PERIOD) bits) increments per pop, wraps; wrap to 0 sets sync_pending.
REQ-026 Words leave in push order; rd_ptr advances by popcount(en_rd).

Reset
REQ-027 Asserting reset immediately clears pointers, level=0, full=0, overflow=0, pop_cnt=0, lane_ok_reg=0, laneok_pending=0; sets sync_pending=1.
REQ-028 pop and wr_en ignored while reset high; en_rd=00, data_rd={IDLE,IDLE}.
REQ-029 Reset mid-stream discards buffered words; first pop after release emits SYNC in [11:0].

Structure
REQ-030 IDLE, SYNC, LANEOK_HEAD live in shared package pcs_codes_pkg, also used by checkers.
REQ-031 One sub-module natural: tx_fifo_mem (DEPTH x 12 dual-port register array, 1 write, 2 async read ports).

Verification
REQ-032 Reset release, pop with empty FIFO -> en_rd=00, data_rd={IDLE,SYNC}; next pop -> {IDLE,IDLE}.
REQ-033 After initial SYNC, push 0x008,0x010,0x018; pop x2 -> 11/{0x010,0x008}, then 01/{IDLE,0x018}.
REQ-034 Push 17 words into DEPTH=16 -> full=1 after 16th, overflow=1 after 17th, level=16; 17th word never emitted.
REQ-035 Force pop_cnt wrap (256 pops) with level=3 -> en_rd=10, [11:0]=SYNC, [23:12]=oldest; next pop 11 with next two words in order.
REQ-036 lane_ok 0x00->0x3C with level=1 -> next pop 01/{0xB3C,word}; following pop IDLE fill.
REQ-037 Assert reset with level=8 mid-pop -> en_rd=00 during reset, level=0, overflow=0; first post-reset pop shows SYNC.
